// File: rtl/uart_stream_pkg.sv
// Shared definitions for the UART stream transceiver.
//   - Tx / Rx state enumerations
//   - Bit-timing constants (16 ticks per bit, mid-bit sample on tick 7)
//   - Reset value of the 16x tick divisor (50 MHz / 115200 / 16)
package uart_stream_pkg;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned SAMPLE_TICK   = 7;
  localparam logic [15:0] CLK_DIV_RST   = 16'd26;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// 16x oversampling tick generator.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset (count 0, divisor DIV_RST)
//   load_i  - when high the divisor register takes div_i
//   div_i   - requested divisor; one tick every div+1 cycles
//   tick_o  - single-cycle tick
module uart_tick_gen #(
  parameter logic [15:0] DIV_RST = 16'd26
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] div_q;

  // '>=' rather than '==' so a divisor lowered below the running count
  // wraps at once instead of counting through 65535.
  assign tick_o = (cnt_q >= div_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      div_q <= DIV_RST;
    end else begin
      if (load_i) div_q <= div_i;
      cnt_q <= tick_o ? '0 : cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/uart_stream_xcvr.sv
// UART transceiver with byte-stream (valid/ready) interfaces on both sides.
// Ports:
//   clk_i, rst_i                       - clock, synchronous active-high reset
//   clk_div_i                          - 16x tick divisor, taken while Tx and Rx are idle
//   parity_en_i, parity_odd_i          - parity enable / odd select (latched per frame)
//   two_stop_i                         - two Tx stop bits (latched per frame)
//   tx_data_i, tx_valid_i, tx_ready_o  - Tx byte stream
//   rx_data_o, rx_valid_o, rx_ready_i  - Rx byte stream (one-entry holding register)
//   rx_frame_err_o                     - framing/parity error of the held byte
//   rx_overrun_o                       - 1-cycle pulse when a received byte is dropped
//   stx_pad_o, srx_pad_i               - serial line, idle high
module uart_stream_xcvr #(
  parameter logic [15:0] CLK_DIV_RST = 16'd26
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] clk_div_i,
  input  logic        parity_en_i,
  input  logic        parity_odd_i,
  input  logic        two_stop_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        rx_frame_err_o,
  output logic        rx_overrun_o,
  output logic        stx_pad_o,
  input  logic        srx_pad_i
);

  import uart_stream_pkg::*;

  localparam logic [4:0] TX_BIT_LAST   = 5'(TICKS_PER_BIT - 1);
  localparam logic [4:0] TX_STOP2_LAST = 5'(2 * TICKS_PER_BIT - 1);
  localparam logic [3:0] RX_SAMPLE     = 4'(SAMPLE_TICK);
  localparam logic [3:0] RX_BIT_LAST   = 4'(TICKS_PER_BIT - 1);

  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic tick;
  logic engines_idle;

  tx_state_t  tx_state_q, tx_state_d;
  logic [4:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_par_q, tx_par_d;
  logic       tx_paren_q, tx_paren_d;
  logic       tx_stop2_q, tx_stop2_d;
  logic       stx_q, stx_d;
  logic       tx_line_bit;
  logic       tx_bit_end;

  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_paren_q, rx_paren_d;
  logic       rx_parodd_q, rx_parodd_d;
  logic       rx_perr_q, rx_perr_d;
  logic       rx_done, rx_done_err;
  logic       srx_p0, srx_p1;
  logic       rx_in;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_err_q, rx_err_d;
  logic       rx_ovr_q, rx_ovr_d;

  assign engines_idle = (tx_state_q == TX_IDLE) && (rx_state_q == RX_IDLE);

  uart_tick_gen #(.DIV_RST(CLK_DIV_RST)) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (engines_idle),
    .div_i  (clk_div_i),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------- Tx
  assign tx_ready_o = (tx_state_q == TX_IDLE) && !rst_i;
  assign stx_pad_o  = stx_q;

  always_comb begin
    case (tx_state_q)
      TX_START:  tx_line_bit = 1'b0;
      TX_DATA:   tx_line_bit = tx_shift_q[0];
      TX_PARITY: tx_line_bit = tx_par_q;
      default:   tx_line_bit = 1'b1;
    endcase
    if (tx_state_q == TX_STOP)
      tx_bit_end = (tx_tcnt_q == (tx_stop2_q ? TX_STOP2_LAST : TX_BIT_LAST));
    else
      tx_bit_end = (tx_tcnt_q == TX_BIT_LAST);
  end

  // A bit is driven onto the line on the first tick counted in its state,
  // so the start bit falls on the first tick after acceptance.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_paren_d = tx_paren_q;
    tx_stop2_d = tx_stop2_q;
    stx_d      = stx_q;
    if (tx_state_q == TX_IDLE) begin
      stx_d = 1'b1;
      if (tx_valid_i && tx_ready_o) begin
        tx_state_d = TX_START;
        tx_tcnt_d  = '0;
        tx_bit_d   = '0;
        tx_shift_d = tx_data_i;
        tx_par_d   = parity_of(tx_data_i, parity_odd_i);
        tx_paren_d = parity_en_i;
        tx_stop2_d = two_stop_i;
      end
    end else if (tick) begin
      tx_tcnt_d = tx_tcnt_q + 5'd1;
      if (tx_tcnt_q == '0) stx_d = tx_line_bit;
      if (tx_bit_end) begin
        tx_tcnt_d = '0;
        case (tx_state_q)
          TX_START: tx_state_d = TX_DATA;
          TX_DATA: begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = tx_paren_q ? TX_PARITY : TX_STOP;
          end
          TX_PARITY: tx_state_d = TX_STOP;
          default:   tx_state_d = TX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      stx_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      stx_q      <= stx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    tx_bit_q   <= tx_bit_d;
    tx_shift_q <= tx_shift_d;
    tx_par_q   <= tx_par_d;
    tx_paren_q <= tx_paren_d;
    tx_stop2_q <= tx_stop2_d;
  end

  // ---------------------------------------------------------------- Rx sync
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      srx_p0 <= 1'b1;
      srx_p1 <= 1'b1;
    end else begin
      srx_p0 <= srx_pad_i;
      srx_p1 <= srx_p0;
    end
  end

  assign rx_in = srx_p1;

  // ---------------------------------------------------------------- Rx FSM
  // Only one stop bit is sampled; returning to IDLE at its mid-point lets
  // a following start edge be caught even with a short stop bit.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tcnt_d   = rx_tcnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_paren_d  = rx_paren_q;
    rx_parodd_d = rx_parodd_q;
    rx_perr_d   = rx_perr_q;
    rx_done     = 1'b0;
    rx_done_err = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      if (!rx_in) begin
        rx_state_d  = RX_START;
        rx_tcnt_d   = '0;
        rx_bit_d    = '0;
        rx_paren_d  = parity_en_i;
        rx_parodd_d = parity_odd_i;
        rx_perr_d   = 1'b0;
      end
    end else if (tick) begin
      rx_tcnt_d = rx_tcnt_q + 4'd1;
      if (rx_tcnt_q == RX_SAMPLE) begin
        case (rx_state_q)
          RX_START:  if (rx_in) rx_state_d = RX_IDLE;
          RX_DATA:   rx_shift_d = {rx_in, rx_shift_q[7:1]};
          RX_PARITY: rx_perr_d = (rx_in != parity_of(rx_shift_q, rx_parodd_q));
          RX_STOP: begin
            rx_state_d  = RX_IDLE;
            rx_done     = 1'b1;
            rx_done_err = !rx_in || rx_perr_q;
          end
          default: ;
        endcase
      end else if (rx_tcnt_q == RX_BIT_LAST) begin
        case (rx_state_q)
          RX_START: rx_state_d = RX_DATA;
          RX_DATA: begin
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = rx_paren_q ? RX_PARITY : RX_STOP;
          end
          RX_PARITY: rx_state_d = RX_STOP;
          default: ;
        endcase
      end
    end
  end

  // Holding register: a same-cycle consume frees the slot for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_err_d   = rx_err_q;
    rx_ovr_d   = 1'b0;
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
    end
    if (rx_done) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        rx_err_d   = rx_done_err;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rx_bit_q    <= rx_bit_d;
    rx_shift_q  <= rx_shift_d;
    rx_paren_q  <= rx_paren_d;
    rx_parodd_q <= rx_parodd_d;
    rx_perr_q   <= rx_perr_d;
  end

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_frame_err_o = rx_err_q;
  assign rx_overrun_o   = rx_ovr_q;

endmodule

// File: tb/tb_uart_stream_xcvr.sv
// Self-checking bench for uart_stream_xcvr: a line-level model of the UART
// frame (bit list, parity by population count) drives expectations.
module tb_uart_stream_xcvr;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] clk_div_i;
  logic        parity_en_i, parity_odd_i, two_stop_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i, tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, rx_ready_i;
  logic        rx_frame_err_o, rx_overrun_o;
  logic        stx_pad_o, srx_pad_i;
  logic        loop_en, srx_drv;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;

  assign srx_pad_i = loop_en ? stx_pad_o : srx_drv;

  always #5 clk_i = ~clk_i;

  uart_stream_xcvr dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_div_i(clk_div_i),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .two_stop_i(two_stop_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_frame_err_o(rx_frame_err_o), .rx_overrun_o(rx_overrun_o),
    .stx_pad_o(stx_pad_o), .srx_pad_i(srx_pad_i)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Parity bit value: odd parity makes the total count of ones odd.
  function automatic bit model_parity(input logic [7:0] d, input bit odd);
    int ones;
    ones = $countones(d);
    return odd ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  task automatic wait_tx_ready(input string tag);
    int g = 0;
    while (!tx_ready_o && g < 3000) begin @(negedge clk_i); g++; end
    checks++;
    if (tx_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s tx_ready_wait got %b want 1", tag, tx_ready_o);
    end
  endtask

  // Send a byte at div=0 and compare the line against the modelled frame.
  task automatic tx_frame_check(input logic [7:0] d, input bit pen, input bit pod,
                                input bit st2, input string tag);
    bit bits[$];
    int n_ticks;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(model_parity(d, pod));
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    n_ticks = 16 * bits.size();
    parity_en_i = pen; parity_odd_i = pod; two_stop_i = st2;
    wait_tx_ready(tag);
    tx_data_i = d; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    parity_en_i = 1'($urandom); parity_odd_i = 1'($urandom); two_stop_i = 1'($urandom);
    checks++;
    if (stx_pad_o !== 1'b1 || tx_ready_o !== 1'b0) begin
      errors++; $display("FAIL %s accept stx=%b ready=%b want stx=1 ready=0", tag, stx_pad_o, tx_ready_o);
    end
    for (int n = 1; n <= n_ticks; n++) begin
      @(negedge clk_i);
      checks++;
      if (stx_pad_o !== bits[(n-1)/16]) begin
        errors++; $display("FAIL %s stx cycle %0d got %b want %b", tag, n, stx_pad_o, bits[(n-1)/16]);
      end
      checks++;
      if (tx_ready_o !== 1'(n == n_ticks)) begin
        errors++; $display("FAIL %s tx_ready cycle %0d got %b want %b", tag, n, tx_ready_o, (n == n_ticks));
      end
    end
  endtask

  // Drive one serial frame on srx at div=0 (16 cycles per bit).
  task automatic drive_frame(input logic [7:0] d, input bit has_par, input bit pbit, input bit stopv);
    bit bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(pbit);
    bits.push_back(stopv);
    loop_en = 1'b0;
    foreach (bits[i]) begin
      srx_drv = bits[i];
      repeat (16) begin @(negedge clk_i); if (rx_overrun_o) ov_cnt++; end
    end
    srx_drv = 1'b1;
    repeat (24) begin @(negedge clk_i); if (rx_overrun_o) ov_cnt++; end
  endtask

  task automatic expect_held(input logic [7:0] d, input bit err, input string tag);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== d || rx_frame_err_o !== err) begin
      errors++;
      $display("FAIL %s held got v=%b d=%h e=%b want v=1 d=%h e=%b",
               tag, rx_valid_o, rx_data_o, rx_frame_err_o, d, err);
    end
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    checks++;
    if (rx_valid_o !== 1'b0 || rx_frame_err_o !== 1'b0) begin
      errors++; $display("FAIL %s consume got v=%b e=%b want 0 0", tag, rx_valid_o, rx_frame_err_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if (stx_pad_o !== 1'b1 || tx_ready_o !== 1'b0 || rx_valid_o !== 1'b0 ||
        rx_data_o !== 8'h00 || rx_frame_err_o !== 1'b0 || rx_overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got stx=%b rdy=%b v=%b d=%h e=%b o=%b want 1 0 0 00 0 0",
               stx_pad_o, tx_ready_o, rx_valid_o, rx_data_o, rx_frame_err_o, rx_overrun_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (tx_ready_o !== 1'b1 || stx_pad_o !== 1'b1) begin
      errors++; $display("FAIL reset_release got rdy=%b stx=%b want 1 1", tx_ready_o, stx_pad_o);
    end
  endtask

  task automatic test_tx_frames();
    clk_div_i = 16'd0;
    repeat (3) @(negedge clk_i);
    tx_frame_check(8'hA5, 1'b0, 1'b0, 1'b0, "tx_a5");
    tx_frame_check(8'h07, 1'b1, 1'b1, 1'b0, "tx_07_odd");
    for (int k = 0; k < 4; k++)
      tx_frame_check(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "tx_rand");
  endtask

  task automatic loopback_run(input logic [7:0] bq[$], input bit pen, input bit pod,
                              input bit st2, input string tag);
    parity_en_i = pen; parity_odd_i = pod; two_stop_i = st2;
    fork
      begin : sender
        int lo, hi, cnt, nbits;
        nbits = 10 + int'(pen) + int'(st2);
        lo = (16 * nbits - 1) * 4 + 1;
        hi = 16 * nbits * 4;
        for (int i = 0; i < bq.size(); i++) begin
          wait_tx_ready(tag);
          tx_data_i = bq[i]; tx_valid_i = 1'b1;
          @(negedge clk_i);
          tx_valid_i = 1'b0;
          cnt = 0;
          while (!tx_ready_o && cnt < 5000) begin @(negedge clk_i); cnt++; end
          checks++;
          if (cnt < lo || cnt > hi) begin
            errors++; $display("FAIL %s tx_frame_len got %0d want %0d..%0d", tag, cnt, lo, hi);
          end
        end
      end
      begin : receiver
        int g;
        for (int i = 0; i < bq.size(); i++) begin
          g = 0;
          while (!rx_valid_o && g < 4000) begin @(negedge clk_i); g++; end
          checks++;
          if (rx_valid_o !== 1'b1 || rx_data_o !== bq[i] || rx_frame_err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s rx_byte%0d got v=%b d=%h e=%b want v=1 d=%h e=0",
                     tag, i, rx_valid_o, rx_data_o, rx_frame_err_o, bq[i]);
          end
          @(negedge clk_i);
        end
      end
    join
  endtask

  task automatic test_loopback();
    logic [7:0] q[$];
    clk_div_i = 16'd3; loop_en = 1'b1; rx_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    q = {8'h00, 8'hFF, 8'h55};
    loopback_run(q, 1'b0, 1'b0, 1'b0, "loop_fixed");
    for (int k = 0; k < 2; k++) begin
      q = {8'($urandom), 8'($urandom), 8'($urandom)};
      loopback_run(q, 1'($urandom), 1'($urandom), 1'($urandom), "loop_rand");
    end
    repeat (100) @(negedge clk_i);
    loop_en = 1'b0; rx_ready_i = 1'b0; clk_div_i = 16'd0;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_parity_err();
    parity_en_i = 1'b1; parity_odd_i = 1'b1; two_stop_i = 1'b0;
    drive_frame(8'h07, 1'b1, 1'b1, 1'b1);
    expect_held(8'h07, 1'b1, "rx_07_bad_par");
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      bit pen, pod, bad_par, bad_stop;
      d = 8'($urandom); pen = 1'($urandom); pod = 1'($urandom);
      bad_par = pen && 1'($urandom);
      bad_stop = ($urandom % 4 == 0);
      parity_en_i = pen; parity_odd_i = pod;
      drive_frame(d, pen, model_parity(d, pod) ^ bad_par, !bad_stop);
      expect_held(d, bad_par || bad_stop, "rx_rand_err");
    end
    parity_en_i = 1'b0; parity_odd_i = 1'b0;
  endtask

  task automatic test_glitch();
    int seen = 0;
    logic [7:0] d;
    srx_drv = 1'b0;
    repeat (5) @(negedge clk_i);
    srx_drv = 1'b1;
    repeat (200) begin @(negedge clk_i); if (rx_valid_o) seen++; end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL glitch_reject got %0d valid cycles want 0", seen);
    end
    d = 8'($urandom);
    drive_frame(d, 1'b0, 1'b0, 1'b1);
    expect_held(d, 1'b0, "glitch_then_frame");
  endtask

  task automatic test_overrun();
    logic [7:0] a, b;
    a = 8'($urandom); b = ~a;
    rx_ready_i = 1'b0; ov_cnt = 0;
    drive_frame(a, 1'b0, 1'b0, 1'b1);
    drive_frame(b, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ov_cnt != 1) begin
      errors++; $display("FAIL overrun_pulses got %0d want 1", ov_cnt);
    end
    expect_held(a, 1'b0, "overrun_keep_first");
  endtask

  task automatic test_reset_midframe();
    int seen_v = 0, seen_lo = 0;
    logic [7:0] d;
    d = 8'($urandom) & 8'hFB;
    clk_div_i = 16'd0; loop_en = 1'b1; rx_ready_i = 1'b0;
    parity_en_i = 1'b0; two_stop_i = 1'b0;
    repeat (3) @(negedge clk_i);
    wait_tx_ready("rst_mid");
    tx_data_i = d; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    repeat (50) @(negedge clk_i);
    checks++;
    if (stx_pad_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pre_line got %b want 0", stx_pad_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (stx_pad_o !== 1'b1 || tx_ready_o !== 1'b0 || rx_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_abort got stx=%b rdy=%b v=%b want 1 0 0",
                         stx_pad_o, tx_ready_o, rx_valid_o);
    end
    rst_i = 1'b0;
    repeat (400) begin
      @(negedge clk_i);
      if (rx_valid_o) seen_v++;
      if (!stx_pad_o) seen_lo++;
    end
    checks++;
    if (seen_v != 0 || seen_lo != 0) begin
      errors++; $display("FAIL rst_mid_after got valid_cycles=%0d low_cycles=%0d want 0 0", seen_v, seen_lo);
    end
    checks++;
    if (tx_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready got %b want 1", tx_ready_o);
    end
    loop_en = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; clk_div_i = 16'd0;
    parity_en_i = 1'b0; parity_odd_i = 1'b0; two_stop_i = 1'b0;
    tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
    loop_en = 1'b0; srx_drv = 1'b1;
    test_reset();
    test_tx_frames();
    test_loopback();
    test_parity_err();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
